// File: rtl/bit_serial_alu_seq.sv
// Sequencer for a 1-bit ALU cell. It walks two WIDTH-bit operands LSB-first through the cell
// and assembles the returned result and carry bits into WIDTH-bit vectors.
module bit_serial_alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] cout_vec_o,
    output logic             zero_o,
    output logic             alu_in1_o,
    output logic             alu_in2_o,
    output logic [1:0]       alu_ctrl_o,
    input  logic             alu_out_i,
    input  logic             alu_cout_i
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [1:0]       op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] cout_q, cout_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] cout_shift;

    always_comb begin
        // New bits enter at the MSB so capture k ends up in bit k after WIDTH captures.
        res_shift  = (result_q >> 1) | (WIDTH'(alu_out_i) << (WIDTH - 1));
        cout_shift = (cout_q >> 1) | (WIDTH'(alu_cout_i) << (WIDTH - 1));

        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    op_d     = op_i;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = '0;
                    zero_d   = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                result_d = res_shift;
                cout_d   = cout_shift;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                if (cnt_q == LastCnt) begin
                    zero_d  = (res_shift == '0);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    assign busy_o     = (state_q == StRun);
    assign done_o     = (state_q == StDone);
    assign result_o   = result_q;
    assign cout_vec_o = cout_q;
    assign zero_o     = zero_q;
    assign alu_in1_o  = busy_o & a_sh_q[0];
    assign alu_in2_o  = busy_o & b_sh_q[0];
    assign alu_ctrl_o = op_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Scoreboard bench for bit_serial_alu_seq: an 8-bit and a 1-bit instance, each driving an
// XOR/AND cell model, with expected responses queued at issue and checked on done.
module tb_bit_serial_alu_seq;

    typedef struct {
        logic [7:0] res;
        logic [7:0] cv;
        logic       z;
    } exp8_t;

    typedef struct {
        logic res;
        logic cv;
        logic z;
    } exp1_t;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;

    logic       start8 = 1'b0;
    logic [1:0] op8 = 2'b00;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       busy8, done8, zero8, in1_8, in2_8, out8, cout8;
    logic [7:0] res8, cv8;
    logic [1:0] ctrl8;

    logic       start1 = 1'b0;
    logic [1:0] op1 = 2'b00;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       busy1, done1, zero1, in1_1, in2_1, out1, cout1, res1, cv1;
    logic [1:0] ctrl1;

    int checks = 0;
    int errors = 0;
    exp8_t q8[$];
    exp1_t q1[$];

    always #5 if (clk_en) clk = ~clk;

    assign out8  = in1_8 ^ in2_8;
    assign cout8 = in1_8 & in2_8;
    assign out1  = in1_1 ^ in2_1;
    assign cout1 = in1_1 & in2_1;

    bit_serial_alu_seq #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .result_o(res8), .cout_vec_o(cv8), .zero_o(zero8),
        .alu_in1_o(in1_8), .alu_in2_o(in2_8), .alu_ctrl_o(ctrl8),
        .alu_out_i(out8), .alu_cout_i(cout8)
    );

    bit_serial_alu_seq #(.WIDTH(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .op_i(op1), .a_i(a1), .b_i(b1),
        .busy_o(busy1), .done_o(done1), .result_o(res1), .cout_vec_o(cv1), .zero_o(zero1),
        .alu_in1_o(in1_1), .alu_in2_o(in2_1), .alu_ctrl_o(ctrl1),
        .alu_out_i(out1), .alu_cout_i(cout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each bit position goes through the cell independently.
    function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b);
        exp8_t e;
        for (int i = 0; i < 8; i++) begin
            e.res[i] = a[i] ^ b[i];
            e.cv[i]  = a[i] & b[i];
        end
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    function automatic exp1_t model1(input logic a, input logic b);
        exp1_t e;
        e.res = a ^ b;
        e.cv  = a & b;
        e.z   = ~(a ^ b);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 32'd1, 32'd0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                chk("result8", 32'(res8), 32'(e.res));
                chk("cout_vec8", 32'(cv8), 32'(e.cv));
                chk("zero8", 32'(zero8), 32'(e.z));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                chk("done1_unexpected", 32'd1, 32'd0);
            end else begin
                exp1_t e;
                e = q1.pop_front();
                chk("result1", 32'(res1), 32'(e.res));
                chk("cout_vec1", 32'(cv1), 32'(e.cv));
                chk("zero1", 32'(zero1), 32'(e.z));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic run_op8(input logic [7:0] a_v, input logic [7:0] b_v, input logic [1:0] op_v,
                           input bit hold);
        exp8_t e;
        e = model8(a_v, b_v);
        a8 = a_v;
        b8 = b_v;
        op8 = op_v;
        start8 = 1'b1;
        q8.push_back(e);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!hold) start8 = 1'b0;
            chk("busy_run", 32'(busy8), 32'd1);
            chk("done_run", 32'(done8), 32'd0);
            chk("ctrl_run", 32'(ctrl8), 32'(op_v));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            op8 = 2'($urandom);
        end
        @(negedge clk);
        chk("done_pulse", 32'(done8), 32'd1);
        chk("busy_done", 32'(busy8), 32'd0);
        @(negedge clk);
        chk("done_clear", 32'(done8), 32'd0);
        chk("busy_idle", 32'(busy8), 32'd0);
        chk("in_idle", {30'd0, in1_8, in2_8}, 32'd0);
        chk("ctrl_idle", 32'(ctrl8), 32'(op_v));
        chk("res_hold", 32'(res8), 32'(e.res));
        chk("zero_hold", 32'(zero8), 32'(e.z));
    endtask

    task automatic run_op1(input logic a_v, input logic b_v, input logic [1:0] op_v);
        q1.push_back(model1(a_v, b_v));
        a1 = a_v;
        b1 = b_v;
        op1 = op_v;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", 32'(busy1), 32'd1);
        chk("w1_ctrl", 32'(ctrl1), 32'(op_v));
        @(negedge clk);
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_busy_done", 32'(busy1), 32'd0);
        @(negedge clk);
        chk("w1_done_clear", 32'(done1), 32'd0);
    endtask

    initial begin
        // Reset with no clock running must clear outputs immediately.
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_result", 32'(res8), 32'd0);
        chk("rst_cout_vec", 32'(cv8), 32'd0);
        chk("rst_zero", 32'(zero8), 32'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op8(8'hA5, 8'h0F, 2'b10, 1'b0);
        run_op8(8'h3C, 8'h3C, 2'b01, 1'b0);
        run_op8(8'h01, 8'h00, 2'b11, 1'b0);

        // Start held high: accepted once per WIDTH+2 cycles, mid-run input changes ignored.
        for (int i = 0; i < 3; i++) run_op8(8'hFF, 8'h00, 2'($urandom), 1'b1);
        start8 = 1'b0;

        for (int i = 0; i < 20; i++) run_op8(8'($urandom), 8'($urandom), 2'($urandom), 1'b0);

        // Abort on the 4th RUN cycle.
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        op8 = 2'b11;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_result", 32'(res8), 32'd0);
        chk("abort_cout_vec", 32'(cv8), 32'd0);
        chk("abort_zero", 32'(zero8), 32'd0);
        chk("abort_alu", {29'd0, in1_8, in2_8, ctrl8 != 2'b00}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_abort_done", 32'(done8), 32'd0);
        end
        chk("post_abort_result", 32'(res8), 32'd0);
        run_op8(8'h81, 8'h01, 2'b00, 1'b0);

        run_op1(1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 6; i++) run_op1(1'($urandom), 1'($urandom), 2'($urandom));

        repeat (3) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Sequencer that sits directly upstream of the team's 1-bit ALU cell. It drives the cell's two operand bits and its 2-bit control, and consumes its result bit and carry-out.
- Accepts a WIDTH-bit operation request, walks the operands LSB-first through the cell one bit per clock, and assembles the per-bit outputs into WIDTH-bit result and carry vectors.
- Signals completion with a one-cycle done pulse and a zero flag.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  request strobe; sampled only in IDLE.
op  in  2  ALU control code for the whole operation; passed unmodified to the cell.
a  in  WIDTH  operand 1.
b  in  WIDTH  operand 2.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse in DONE.
result  out  WIDTH  assembled cell outputs; bit i = cell result for operand bit i.
cout_vec  out  WIDTH  assembled cell carry-outs; bit i = cell Cout for operand bit i.
zero  out  1  high when result == 0; valid with done; held afterwards.
alu_in1  out  1  operand-1 bit to the cell.
alu_in2  out  1  operand-2 bit to the cell.
alu_ctrl  out  2  control to the cell.
alu_out  in  1  result bit from the cell (combinational from alu_in1/alu_in2/alu_ctrl).
alu_cout  in  1  carry-out from the cell.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - busy = 0, done = 0, zero = 0.
  - result, cout_vec and the internal shift registers = 0.
  - bit counter = 0; latched op = 0.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - If start = 1 at a rising edge, latch a, b and op into internal registers, clear the counter, clear result and cout_vec, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - alu_in1 = a_sh[0], alu_in2 = b_sh[0], alu_ctrl = op_q (combinational from registers).
  - At each rising edge:
    - Shift alu_out into result from the MSB side (result <= {alu_out, result[WIDTH-1:1]}); treat cout_vec the same way with alu_cout.
    - Shift a_sh and b_sh right by 1 with zero fill.
    - Increment the counter.
  - When the counter reaches WIDTH-1 at an edge, take that final capture and go to DONE.
  - After WIDTH captures, the bit driven at capture k is in result[k].
- DONE:
  - done = 1 for exactly one cycle.
  - zero = (result == 0), registered on entry to DONE.
  - Next edge goes unconditionally to IDLE.
- Latency: start sampled at edge T gives bits on edges T+1..T+WIDTH, done high in the cycle after edge T+WIDTH, and IDLE after edge T+WIDTH+1. Back-to-back throughput is one op per WIDTH+2 cycles.
- Outside RUN: alu_in1 = 0, alu_in2 = 0, alu_ctrl = op_q (last latched op).
- result, cout_vec and zero hold their values from DONE until the next accepted start.
- start in RUN or DONE is ignored and not queued.
- Changes to a, b or op after acceptance have no effect on the running operation.
- WIDTH = 1: RUN lasts one cycle; done follows immediately.
- Counter width is clog2(WIDTH), minimum 1 bit. It never wraps within an operation.
- rst asserted mid-RUN aborts the operation: no done pulse and all outputs cleared. After release the block returns to IDLE and accepts start on the first edge.
- No combinational path from alu_out or alu_cout to any output. The combinational path start → alu_* is prohibited.

Test Plan:
Bench cell model for all tests: alu_out = in1 ^ in2, alu_cout = in1 & in2.
1. Reset: rst = 1 mid-cycle, no clock → busy = 0, done = 0, result = 0x00, cout_vec = 0x00, zero = 0 immediately.
2. WIDTH = 8, a = 0xA5, b = 0x0F, op = 2'b10, one start → busy for 8 cycles; alu_ctrl = 2'b10 throughout; done pulse on cycle 9 after start; result = 0xAA; cout_vec = 0x05; zero = 0.
3. a = 0x3C, b = 0x3C → result = 0x00, cout_vec = 0x3C, zero = 1 with done. Then start with a = 0x01, b = 0x00 → zero = 0, result = 0x01.
4. Start held high continuously with a = 0xFF, b = 0x00 → accepted once per 10 cycles. Ops in RUN/DONE are ignored, and a/b toggling mid-run does not change result = 0xFF.
5. rst pulsed on the 4th RUN cycle → no done; after release all outputs are 0. A new start with a = 0x81, b = 0x01 gives result = 0x80, cout_vec = 0x01.
6. WIDTH = 1, a = 1, b = 1 → busy for one cycle, done on the next, result = 0, cout_vec = 1, zero = 1.
